mem_responder: RTL and testbench

//  Memory-side responder for the CPU's data-memory request interface.
//  It accepts one read or write request at a time and holds it for a fixed, multi-cycle latency.

---
 rtl/mem_responder_pkg.sv | 27 ++
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder_word_array.sv | 27 ++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: FSM encoding,
// default geometry/latency and the debug view of the controller.
package mem_responder_pkg;

  localparam int DATA_W          = 16;
  localparam int CNT_W           = 4;
  localparam int DEFAULT_ADDR_W  = 10;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_wr;
  } dbg_t;

  // The counter is loaded with LATENCY-1, so LATENCY must fit in CNT_W bits.
  function automatic bit latency_ok(input int lat);
    return (lat >= 1) && (lat <= (1 << CNT_W) - 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU data-memory request bus between the EX/MEM stage and the responder.
interface mem_responder_if;

  // Handshake: a request is taken on any rising edge where req_en = 1 and
  // the responder is not busy (mem_ready = 1 in the cycle before the edge).
  // req_wr/req_addr/req_wdata matter only at that edge; while mem_ready = 0
  // the CPU freezes and the responder ignores every request input.
  logic        req_en;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        mem_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        busy_wr;

  modport master (
    output req_en, req_wr, req_addr, req_wdata,
    input  mem_ready, rdata, rdata_valid, busy_wr
  );

  modport slave (
    input  req_en, req_wr, req_addr, req_wdata,
    output mem_ready, rdata, rdata_valid, busy_wr
  );

endinterface

// File: rtl/mem_responder_word_array.sv
// Word storage: synchronous write, registered read, no reset (contents
// survive a controller reset).
module mem_word_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-before-write on a same-address collision; the controller never
  // needs the bypass because a read is always accepted after the write's
  // commit edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls the CPU via
// mem_ready for LATENCY cycles, then commits the write or returns read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_if.slave        bus,
  output dbg_t                  dbg
);

  generate
    if (!latency_ok(LATENCY)) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 14) begin : g_bad_addr_w
      $error("mem_responder: ADDR_W must be in 1..14");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_word;
  logic [DATA_W-1:0]   lat_wdata;
  logic                mem_ready_q;
  logic                rdata_valid_q;
  logic                busy_wr_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                accept;
  logic                finish;
  logic [ADDR_W-1:0]   req_word;
  logic [ADDR_W-1:0]   arr_raddr;
  logic [DATA_W-1:0]   arr_rdata;
  logic                arr_we;
  logic                unused_addr_bits;

  // Byte address to word index; bits above ADDR_W alias.
  assign req_word         = bus.req_addr[ADDR_W:1];
  assign unused_addr_bits = ^{bus.req_addr[15:ADDR_W+1], bus.req_addr[0]};

  assign accept = bus.req_en && (state != ST_BUSY);
  assign finish = (state == ST_BUSY) && (cnt == '0);
  assign arr_we = finish && lat_wr;

  // Point the array at the incoming word on the accepting edge so that a
  // LATENCY = 1 read already has its data registered one edge later.
  assign arr_raddr = accept ? req_word : lat_word;

  mem_word_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (lat_word),
    .wdata (lat_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      lat_wr        <= 1'b0;
      lat_word      <= '0;
      lat_wdata     <= '0;
      mem_ready_q   <= 1'b1;
      rdata_valid_q <= 1'b0;
      busy_wr_q     <= 1'b0;
      rdata_q       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          rdata_valid_q <= 1'b0;
          if (accept) begin
            state       <= ST_BUSY;
            cnt         <= CNT_LOAD;
            lat_wr      <= bus.req_wr;
            lat_word    <= req_word;
            lat_wdata   <= bus.req_wdata;
            mem_ready_q <= 1'b0;
            busy_wr_q   <= bus.req_wr;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state       <= ST_DONE;
            mem_ready_q <= 1'b1;
            busy_wr_q   <= 1'b0;
            if (!lat_wr) begin
              rdata_q       <= arr_rdata;
              rdata_valid_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          mem_ready_q <= 1'b1;
          busy_wr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_ready   = mem_ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.busy_wr     = busy_wr_q;

  assign dbg.state  = state;
  assign dbg.cnt    = cnt;
  assign dbg.lat_wr = lat_wr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY = 4 instance and a LATENCY = 1
// instance sharing clock and reset, with hand-computed expectations.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  dbg_t dbg4;
  dbg_t dbg1;

  mem_responder_if bus4 ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_W(10), .LATENCY(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4),
    .dbg   (dbg4)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .dbg   (dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input bit sel, input logic en, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata);
    if (sel) begin
      bus1.req_en = en; bus1.req_wr = wr; bus1.req_addr = addr; bus1.req_wdata = wdata;
    end else begin
      bus4.req_en = en; bus4.req_wr = wr; bus4.req_addr = addr; bus4.req_wdata = wdata;
    end
  endtask

  task automatic sample(input bit sel, output logic rdy, output logic vld,
                        output logic bw, output logic [15:0] rd);
    if (sel) begin
      rdy = bus1.mem_ready; vld = bus1.rdata_valid; bw = bus1.busy_wr; rd = bus1.rdata;
    end else begin
      rdy = bus4.mem_ready; vld = bus4.rdata_valid; bw = bus4.busy_wr; rd = bus4.rdata;
    end
  endtask

  // One request held for a single cycle on an idle DUT; observes a fixed
  // window of lat+4 cycles starting with the cycle after the accepting edge.
  task automatic do_op(input bit sel, input int lat, input string tag, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd);
    int low, bwc, vcnt, voff;
    logic rdy, vld, bw;
    logic [15:0] rd, rdv;
    low = 0; bwc = 0; vcnt = 0; voff = -1; rdv = '0; rd = '0;
    drive_req(sel, 1'b1, wr, addr, wdata);
    @(posedge clk);
    #1 drive_req(sel, 1'b0, wr, addr, wdata);
    for (int o = 0; o < lat + 4; o++) begin
      @(negedge clk);
      sample(sel, rdy, vld, bw, rd);
      if (!rdy) low++;
      if (bw) bwc++;
      if (vld) begin
        vcnt++;
        if (voff < 0) voff = o;
        rdv = rd;
      end
    end
    check({tag, ".ready_low"}, 16'(low), 16'(lat));
    check({tag, ".busy_wr"}, 16'(bwc), wr ? 16'(lat) : 16'd0);
    if (wr) begin
      check({tag, ".no_valid"}, 16'(vcnt), 16'd0);
    end else begin
      check({tag, ".valid_cnt"}, 16'(vcnt), 16'd1);
      check({tag, ".valid_off"}, 16'(voff), 16'(lat));
      check({tag, ".rdata"}, rdv, exp_rd);
      check({tag, ".rdata_hold"}, rd, exp_rd);
    end
  endtask

  // scoreboard of expected read data for the back-to-back run
  logic [15:0] exp_q[$];

  initial begin
    logic rdy, vld, bw;
    logic [15:0] rd;
    int low;
    n_vec = 0;
    n_err = 0;
    drive_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    // 1. reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.ready", 16'(bus4.mem_ready), 16'd1);
    check("rst.rdata", bus4.rdata, 16'h0000);
    check("rst.valid", 16'(bus4.rdata_valid), 16'd0);
    check("rst.busy_wr", 16'(bus4.busy_wr), 16'd0);
    check("rst.state", 16'(dbg4.state), 16'(ST_IDLE));
    @(negedge clk);

    // 2. write then read
    do_op(1'b0, 4, "wr_beef", 1'b1, 16'h0010, 16'hBEEF, 16'h0);
    do_op(1'b0, 4, "rd_beef", 1'b0, 16'h0010, 16'h0, 16'hBEEF);

    // 3. back-to-back with req_en held across both requests
    exp_q.push_back(16'h1234);
    drive_req(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    @(posedge clk);
    #1;
    low = 0;
    for (int o = 0; o <= 10; o++) begin
      @(negedge clk);
      sample(1'b0, rdy, vld, bw, rd);
      if (!rdy) low++;
      if (o == 4) begin
        check("b2b.done_ready", 16'(rdy), 16'd1);
        check("b2b.done_state", 16'(dbg4.state), 16'(ST_DONE));
        bus4.req_wr = 1'b0;
      end
      if (o == 5) begin
        check("b2b.second_accept", 16'(dbg4.state), 16'(ST_BUSY));
        bus4.req_en = 1'b0;
      end
      if (o == 9) begin
        check("b2b.valid", 16'(vld), 16'd1);
        check("b2b.rdata", rd, exp_q.pop_front());
      end
      if (o == 10) begin
        check("b2b.valid_drop", 16'(vld), 16'd0);
        check("b2b.idle", 16'(dbg4.state), 16'(ST_IDLE));
      end
    end
    check("b2b.ready_low", 16'(low), 16'd8);
    check("b2b.queue_empty", 16'(exp_q.size()), 16'd0);

    // 4. input churn while busy
    do_op(1'b0, 4, "pre_1111", 1'b1, 16'h0044, 16'h1111, 16'h0);
    drive_req(1'b0, 1'b1, 1'b1, 16'h0040, 16'hC0DE);
    @(posedge clk);
    #1;
    for (int o = 0; o < 7; o++) begin
      drive_req(1'b0, 1'b0, o[0], (o[0] ? 16'h0044 : 16'h0844), 16'(16'h2222 + o));
      @(negedge clk);
    end
    do_op(1'b0, 4, "churn_rd", 1'b0, 16'h0040, 16'h0, 16'hC0DE);
    do_op(1'b0, 4, "churn_other", 1'b0, 16'h0044, 16'h0, 16'h1111);

    // 5. reset in the middle of a write
    do_op(1'b0, 4, "pre_5555", 1'b1, 16'h0030, 16'h5555, 16'h0);
    do_op(1'b0, 4, "rd_5555", 1'b0, 16'h0030, 16'h0, 16'h5555);
    drive_req(1'b0, 1'b1, 1'b1, 16'h0030, 16'hAAAA);
    @(posedge clk);
    #1 drive_req(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0);
    @(negedge clk);
    check("rstmid.busy_wr", 16'(bus4.busy_wr), 16'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid.ready", 16'(bus4.mem_ready), 16'd1);
    check("rstmid.busy_wr0", 16'(bus4.busy_wr), 16'd0);
    check("rstmid.rdata", bus4.rdata, 16'h0000);
    check("rstmid.state", 16'(dbg4.state), 16'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 4, "rstmid_rd", 1'b0, 16'h0030, 16'h0, 16'h5555);

    // 6. aliasing on the LATENCY = 1 instance
    do_op(1'b1, 1, "l1_wr", 1'b1, 16'h0002, 16'h7777, 16'h0);
    do_op(1'b1, 1, "l1_alias_rd", 1'b0, 16'h0802, 16'h0, 16'h7777);
    do_op(1'b1, 1, "l1_alias_odd", 1'b0, 16'h0803, 16'h0, 16'h7777);
    do_op(1'b1, 1, "l1_wr2", 1'b1, 16'h0004, 16'h4321, 16'h0);
    do_op(1'b1, 1, "l1_rd2", 1'b0, 16'h0004, 16'h0, 16'h4321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
